// File: rtl/pipeline_controller_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler: stall bus patterns
// and controller state encodings.
package pipeline_controller_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_t;

  // stall bits: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
  localparam stall_t STALL_NONE     = 6'b000000;
  localparam stall_t STALL_FROM_ID  = 6'b000111;
  localparam stall_t STALL_FROM_EX  = 6'b001111;
  localparam stall_t STALL_FROM_MEM = 6'b011111;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_MULTI = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_controller_multicycle_counter.sv
// Down-counter sequencing multi-cycle EX operations: load, decrement,
// freeze and zero flag.
module pipeline_controller_multicycle_counter #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec_en,
  input  logic                 freeze,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 zero
);

  // clear (exception abort) wins over load; freeze wins over decrement
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec_en && !freeze && (cnt != '0)) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush scheduler for the five-stage pipeline: hazard priority
// mux, PC redirect, multi-cycle EX sequencing FSM and stall-cycle perf counter.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_stall_request,
  input  logic        ex_multicycle_start,
  input  logic        mem_stall_request,
  input  logic        mem_exception,
  input  logic [31:0] mem_exception_vector,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        ex_multicycle_ready,
  output logic        busy,
  output logic [31:0] stall_cycle_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

  ctrl_state_t          state;
  ctrl_state_t          state_next;
  logic                 cnt_clear;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_freeze;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_zero;
  logic                 multi_hold;
  logic [31:0]          perf_count;

  pipeline_controller_multicycle_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_multicycle_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .load_value(CNT_LOAD),
    .dec_en    (cnt_dec),
    .freeze    (cnt_freeze),
    .cnt       (cnt),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CTRL_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next          = state;
    stall               = STALL_NONE;
    flush               = 1'b0;
    pc_redirect         = 1'b0;
    pc_target           = 32'h0;
    ex_multicycle_ready = 1'b0;
    cnt_clear           = 1'b0;
    cnt_load            = 1'b0;
    cnt_dec             = 1'b0;
    cnt_freeze          = 1'b0;
    multi_hold          = 1'b0;

    if (!reset) begin
      if (mem_exception) begin
        // exception aborts any divide in flight; no ready pulse follows
        flush       = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = mem_exception_vector;
        state_next  = CTRL_RUN;
        cnt_clear   = 1'b1;
      end else begin
        multi_hold = ((state == CTRL_MULTI) && !cnt_zero) ||
                     ((state == CTRL_RUN) && ex_multicycle_start);

        if (mem_stall_request) begin
          stall = STALL_FROM_MEM;
        end else if (multi_hold) begin
          stall = STALL_FROM_EX;
        end else if (id_stall_request) begin
          stall = STALL_FROM_ID;
        end

        case (state)
          CTRL_RUN: begin
            // a start under a memory stall is re-presented by EX later
            if (ex_multicycle_start && !mem_stall_request) begin
              state_next = CTRL_MULTI;
              cnt_load   = 1'b1;
            end
          end
          CTRL_MULTI: begin
            cnt_freeze = mem_stall_request;
            cnt_dec    = !cnt_zero;
            if (!mem_stall_request && cnt_zero) begin
              ex_multicycle_ready = 1'b1;
              state_next          = CTRL_RUN;
            end
          end
          default: state_next = CTRL_RUN;
        endcase

        // delay slot executes, so a taken branch never flushes
        if (id_branch_taken && !stall[0]) begin
          pc_redirect = 1'b1;
          pc_target   = id_branch_target;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_count <= 32'h0;
    end else if (stall[0]) begin
      perf_count <= perf_count + 32'h1;
    end
  end

  assign busy              = !reset && (state == CTRL_MULTI);
  assign stall_cycle_count = reset ? 32'h0 : perf_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed test-plan steps then
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_controller;

  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_stall_request = 1'b0;
  logic        ex_multicycle_start = 1'b0;
  logic        mem_stall_request = 1'b0;
  logic        mem_exception = 1'b0;
  logic [31:0] mem_exception_vector = 32'h0;
  logic        id_branch_taken = 1'b0;
  logic [31:0] id_branch_target = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        ex_multicycle_ready;
  logic        busy;
  logic [31:0] stall_cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  // model: a divide is "active" once accepted; done counts the non-mem-stalled
  // cycles it has held EX (acceptance cycle included). Ready once done reaches DC.
  logic        m_active = 1'b0;
  int          m_done = 0;
  logic [31:0] m_count = 32'h0;

  pipeline_controller #(.DIV_CYCLES(DC), .CNT_WIDTH(6)) dut (
    .clock               (clock),
    .reset               (reset),
    .id_stall_request    (id_stall_request),
    .ex_multicycle_start (ex_multicycle_start),
    .mem_stall_request   (mem_stall_request),
    .mem_exception       (mem_exception),
    .mem_exception_vector(mem_exception_vector),
    .id_branch_taken     (id_branch_taken),
    .id_branch_target    (id_branch_target),
    .stall               (stall),
    .flush               (flush),
    .pc_redirect         (pc_redirect),
    .pc_target           (pc_target),
    .ex_multicycle_ready (ex_multicycle_ready),
    .busy                (busy),
    .stall_cycle_count   (stall_cycle_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic cycle(input logic r, input logic idst, input logic start, input logic mst,
                       input logic exc, input logic [31:0] vec,
                       input logic br, input logic [31:0] tgt);
    logic [5:0]  e_stall;
    logic        e_flush, e_red, e_ready, e_busy, hold;
    logic [31:0] e_tgt, e_cnt;
    @(negedge clock);
    reset                = r;
    id_stall_request     = idst;
    ex_multicycle_start  = start;
    mem_stall_request    = mst;
    mem_exception        = exc;
    mem_exception_vector = vec;
    id_branch_taken      = br;
    id_branch_target     = tgt;
    #1;
    e_stall = 6'b000000; e_flush = 1'b0; e_red = 1'b0; e_ready = 1'b0;
    e_busy = 1'b0; hold = 1'b0; e_tgt = 32'h0; e_cnt = 32'h0;
    if (!r) begin
      e_busy = m_active;
      e_cnt  = m_count;
      if (exc) begin
        e_flush = 1'b1;
        e_red   = 1'b1;
        e_tgt   = vec;
      end else begin
        hold = (m_active && m_done < DC) || (!m_active && start);
        if (mst)       e_stall = 6'b011111;
        else if (hold) e_stall = 6'b001111;
        else if (idst) e_stall = 6'b000111;
        e_ready = m_active && (m_done == DC) && !mst;
        if (br && !e_stall[0]) begin
          e_red = 1'b1;
          e_tgt = tgt;
        end
      end
    end
    chk("stall", {26'h0, stall}, {26'h0, e_stall});
    chk("flush", {31'h0, flush}, {31'h0, e_flush});
    chk("pc_redirect", {31'h0, pc_redirect}, {31'h0, e_red});
    chk("pc_target", pc_target, e_tgt);
    chk("ready", {31'h0, ex_multicycle_ready}, {31'h0, e_ready});
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    chk("stall_cycle_count", stall_cycle_count, e_cnt);
    if (r) begin
      m_active = 1'b0;
      m_done   = 0;
      m_count  = 32'h0;
    end else begin
      if (e_stall[0]) m_count = m_count + 32'h1;
      if (exc) begin
        m_active = 1'b0;
      end else if (!m_active && start && !mst) begin
        m_active = 1'b1;
        m_done   = 1;
      end else if (m_active && !mst) begin
        if (m_done == DC) m_active = 1'b0;
        else m_done++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    // reset and quiet run
    cycle(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(2);

    // load-use stall for two cycles
    cycle(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(1);

    // plain divide
    cycle(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    idle(6);

    // divide with memory stall in its third and fourth cycles
    cycle(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    idle(5);

    // exception aborts divide
    cycle(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 0, 1, 32'h0000_0020, 0, 32'h0);
    idle(6);

    // branch blocked by load-use stall, then taken alone
    cycle(0, 1, 0, 0, 0, 32'h0, 1, 32'h0040_0100);
    cycle(0, 0, 0, 0, 0, 32'h0, 1, 32'h0040_0100);

    // id stall honoured in the ready cycle, start under mem stall deferred
    cycle(0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < DC; i++) cycle(0, 1, 1, 0, 0, 32'h0, 1, 32'h1234_5678);
    idle(2);

    // reset mid-divide
    cycle(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199, 0) == 0),
            ($urandom_range(99, 0) < 25),
            ($urandom_range(99, 0) < 30),
            ($urandom_range(99, 0) < 20),
            ($urandom_range(99, 0) < 4),
            $urandom(),
            ($urandom_range(99, 0) < 30),
            $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
